mfp_ahb_uart_tx: RTL and testbench

//  AHB-Lite slave UART transmitter, 8N1: the outbound complement of the UART_RX serial-load path.

---
 rtl/mfp_ahb_uart_tx_pkg.sv | 31 +++
 rtl/mfp_ahb_uart_tx_fifo.sv | 50 +++++
 rtl/mfp_ahb_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_mfp_ahb_uart_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the AHB UART transmitter: register map, STATUS layout,
// FSM encoding and the reset divisor (433 -> 115200 baud at 50 MHz).
package mfp_ahb_uart_tx_pkg;

    localparam int DIV_RESET_DEF = 433;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_IRQ    = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_LEVEL = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [1:0] off;
    } ahb_dphase_t;

endpackage

// File: rtl/mfp_ahb_uart_tx_fifo.sv
// Synchronous TX byte FIFO; pointers wrap modulo DEPTH (power of 2),
// level is one bit wider so a full FIFO is distinguishable from empty.
module mfp_ahb_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop happens the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite zero-wait UART transmitter (8N1): TX FIFO, programmable baud divisor, polled status.
// Define MFP_UART_TX_IRQ_EN to add the R/W IRQ_EN register and the registered TX_INT output.
module mfp_ahb_uart_tx
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = DIV_RESET_DEF
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX
`ifdef MFP_UART_TX_IRQ_EN
   ,output logic        TX_INT
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    ahb_dphase_t   dp_q, dp_d;
    logic [15:0]   div_q;
    logic          ovf_q;
    tx_state_e     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_end, busy, pop, push, full, empty, irq_rd;
    logic          wr_data, wr_status, wr_div;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] level;
    logic [31:0]   status;
    logic          unused_ok;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

    always_comb begin
        dp_d.wr  = HSEL & HTRANS[1] & HREADY & HWRITE;
        dp_d.rd  = HSEL & HTRANS[1] & HREADY & ~HWRITE;
        dp_d.off = HADDR[3:2];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dp_q <= '0;
        else          dp_q <= dp_d;
    end

    assign wr_data   = dp_q.wr && (dp_q.off == OFF_DATA);
    assign wr_status = dp_q.wr && (dp_q.off == OFF_STATUS);
    assign wr_div    = dp_q.wr && (dp_q.off == OFF_DIV);
    assign push      = wr_data;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div_q <= 16'(DIV_RESET);
            ovf_q <= 1'b0;
        end else begin
            if (wr_div) div_q <= HWDATA[15:0];
            if (push && full)                        ovf_q <= 1'b1;
            else if (wr_status && HWDATA[ST_OVF])    ovf_q <= 1'b0;
        end
    end

`ifdef MFP_UART_TX_IRQ_EN
    logic irq_en_q;
    logic wr_irq;
    assign wr_irq = dp_q.wr && (dp_q.off == OFF_IRQ);
    assign irq_rd = irq_en_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en_q <= 1'b0;
            TX_INT   <= 1'b0;
        end else begin
            if (wr_irq) irq_en_q <= HWDATA[0];
            TX_INT <= irq_en_q & empty & ~busy;
        end
    end
`else
    assign irq_rd = 1'b0;
`endif

    always_comb begin
        status               = '0;
        status[ST_BUSY]      = busy;
        status[ST_FULL]      = full;
        status[ST_EMPTY]     = empty;
        status[ST_OVF]       = ovf_q;
        status[ST_LEVEL +: LW] = level;
    end

    always_comb begin
        HRDATA = '0;
        if (dp_q.rd) begin
            case (dp_q.off)
                OFF_STATUS: HRDATA = status;
                OFF_DIV:    HRDATA = {16'h0, div_q};
                OFF_IRQ:    HRDATA = {31'h0, irq_rd};
                default:    HRDATA = '0;
            endcase
        end
    end

    mfp_ahb_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (push),
        .wdata_i (HWDATA[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // Baud counter is reloaded only at bit boundaries, so a DIVISOR write
    // never stretches or shortens the bit already on the line.
    assign bit_end = (cnt_q == 16'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = div_q;
                    bit_d   = 3'd0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    cnt_d   = div_q;
                    state_d = TX_DATA;
                end else cnt_d = cnt_q - 16'd1;
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = TX_STOP;
                end else cnt_d = cnt_q - 16'd1;
            end
            TX_STOP: begin
                if (bit_end) state_d = TX_IDLE;
                else         cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != TX_IDLE);
        UART_TX = 1'b1;
        case (state_q)
            TX_START: UART_TX = 1'b0;
            TX_DATA:  UART_TX = shift_q[0];
            default:  UART_TX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Directed bench for mfp_ahb_uart_tx: reset, frame shape and latency, divisor change
// mid-bit, FIFO overflow and drain order, async reset mid-frame, optional TX_INT.
module tb_mfp_ahb_uart_tx;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP, UART_TX;
`ifdef MFP_UART_TX_IRQ_EN
    logic        TX_INT;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] d;
    logic [7:0]  rb, tb_byte;
    logic        rstp, rto;
    int          lows, c;

    always #5 HCLK = ~HCLK;

    mfp_ahb_uart_tx dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .UART_TX(UART_TX)
`ifdef MFP_UART_TX_IRQ_EN
       ,.TX_INT(TX_INT)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Address phase now, data phase next cycle; returns one cycle after the data phase.
    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, addr};
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        tick();
        HWDATA = '0;
    endtask

    task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, addr};
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        tick();
    endtask

    // Serial receiver sampling mid-bit; returns at the middle of the stop bit.
    task automatic rx_byte(input int per, output logic [7:0] b, output logic stp, output logic to);
        int n = 0;
        b = '0; stp = 1'b0; to = 1'b0;
        while (UART_TX !== 1'b0 && n < 4000) begin tick(); n++; end
        if (n >= 4000) begin to = 1'b1; return; end
        repeat (per / 2) tick();
        for (int k = 0; k < 8; k++) begin
            repeat (per) tick();
            b[k] = UART_TX;
        end
        repeat (per) tick();
        stp = UART_TX;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_tx", UART_TX, 1);
        chk("rst_hready", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        HRESETn = 1'b1;
        tick();
        ahb_read(4'h4, d);  chk("t1_status", d, 32'h004);
        ahb_read(4'h8, d);  chk("t1_div", d, 32'd433);
        chk("t1_tx", UART_TX, 1);

        // Frame shape and write-to-start latency, DIVISOR=3
        ahb_write(4'h8, 32'd3);
        tb_byte = 8'h55;
        ahb_write(4'h0, {24'h0, tb_byte});
        chk("t2_pop_cycle", UART_TX, 1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                if (k == 0)      chk("t2_start", UART_TX, 0);
                else if (k <= 8) chk("t2_data", UART_TX, {31'h0, tb_byte[k-1]});
                else             chk("t2_stop", UART_TX, 1);
            end
        end
        tick();
        chk("t2_idle", UART_TX, 1);
        ahb_read(4'h4, d);  chk("t2_status", d, 32'h004);

        // DIVISOR 3->7 written during data bit 0
        ahb_write(4'h0, 32'h55);
        chk("t4_pop_cycle", UART_TX, 1);
        c = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < ((k <= 1) ? 4 : 8); j++) begin
                tick();
                if (k == 0)      chk("t4_start", UART_TX, 0);
                else if (k <= 8) chk("t4_data", UART_TX, {31'h0, tb_byte[k-1]});
                else             chk("t4_stop", UART_TX, 1);
                if (c == 4) begin HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8; end
                if (c == 5) begin HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'd7; end
                if (c == 6) HWDATA = '0;
                if (c == 20) begin HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4; end
                if (c == 21) begin
                    HSEL = 1'b0; HTRANS = 2'b00;
                    chk("t4_busy", HRDATA[0], 1);
                end
                c++;
            end
        end
        tick();
        ahb_read(4'h8, d);  chk("t4_div", d, 32'd7);

        // Overflow: byte 0 goes straight to the shifter, 16 fill the FIFO, byte 17 is dropped
        ahb_write(4'h8, 32'd63);
        fork
            begin
                for (int i = 0; i < 18; i++) ahb_write(4'h0, 32'hA0 + i);
                ahb_read(4'h4, d);  chk("t3_full_status", d, 32'h10B);
                ahb_write(4'h4, 32'h8);
                ahb_read(4'h4, d);  chk("t3_ovf_clr", d, 32'h103);
                ahb_read(4'h0, d);  chk("t3_data_rd", d, 32'h0);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    rx_byte(64, rb, rstp, rto);
                    chk("t3_rx_timeout", rto, 0);
                    if (rto) break;
                    chk("t3_rx_byte", rb, 32'hA0 + i);
                    chk("t3_rx_stop", rstp, 1);
                end
            end
        join
        repeat (40) tick();
        ahb_read(4'h4, d);  chk("t3_drained", d, 32'h004);

        // Async reset mid-frame
        ahb_write(4'h8, 32'd3);
        ahb_write(4'h0, 32'h12);
        ahb_write(4'h0, 32'h34);
        chk("t5_pre_low", UART_TX, 0);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_high", UART_TX, 1);
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        ahb_read(4'h4, d);  chk("t5_status", d, 32'h004);
        ahb_read(4'h8, d);  chk("t5_div", d, 32'd433);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (UART_TX !== 1'b1) lows++;
        end
        chk("t5_no_residual", lows, 0);

`ifdef MFP_UART_TX_IRQ_EN
        ahb_write(4'h8, 32'd3);
        ahb_write(4'hC, 32'd1);
        ahb_read(4'hC, d);  chk("t6_irq_en_rd", d, 32'd1);
        chk("t6_int_idle", TX_INT, 1);
        ahb_write(4'h0, 32'h81);
        for (int i = 2; i <= 42; i++) begin
            tick();
            chk("t6_int_busy", TX_INT, 0);
        end
        tick();
        chk("t6_int_rise", TX_INT, 1);
        ahb_write(4'hC, 32'd0);
        tick();
        chk("t6_int_off", TX_INT, 0);
`else
        ahb_write(4'hC, 32'd1);
        ahb_read(4'hC, d);  chk("t6_irq_en_absent", d, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
